// File: rtl/axis_uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one AXI-Stream byte sink
// (UART TX input) between N_SRC sources, with optional ID header and gap.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   s_axis_data/valid/last      packed per-source streams (source i at slice i)
//   s_axis_ready                per-source ready (only the owner in DATA)
//   m_axis_data/valid/last      stream to the UART transmitter
//   m_axis_ready                transmitter ready
//   grant                       one-hot current owner, 0 when none
//   busy                        1 whenever not idle
module axis_uart_tx_arbiter #(
  parameter int              DATA_BITS  = 8,
  parameter int              N_SRC      = 4,
  parameter int              HEADER_EN  = 1,
  parameter logic [7:0]      HDR_BASE   = 8'hA0,
  parameter int              GAP_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_SRC*DATA_BITS-1:0] s_axis_data,
  input  logic [N_SRC-1:0]           s_axis_valid,
  input  logic [N_SRC-1:0]           s_axis_last,
  output logic [N_SRC-1:0]           s_axis_ready,
  output logic [DATA_BITS-1:0]       m_axis_data,
  output logic                       m_axis_valid,
  output logic                       m_axis_last,
  input  logic                       m_axis_ready,
  output logic [N_SRC-1:0]           grant,
  output logic                       busy
);

  localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA,
    GAP
  } state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [IW-1:0]     rr_q, rr_d;
  logic [N_SRC-1:0]  grant_q, grant_d;
  logic [GW-1:0]     gap_q, gap_d;

  logic [IW-1:0]        sel;
  logic [DATA_BITS-1:0] src_data;
  logic                 src_vld;
  logic                 src_last;
  logic [DATA_BITS-1:0] hdr;

  assign src_data = s_axis_data[idx_q*DATA_BITS +: DATA_BITS];
  assign src_vld  = s_axis_valid[idx_q];
  assign src_last = s_axis_last[idx_q];
  assign hdr      = DATA_BITS'(32'(HDR_BASE) + 32'(idx_q));

  // Walk the ring downward so the requester closest to rr_q wins.
  always_comb begin
    sel = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (s_axis_valid[(int'(rr_q) + k) % N_SRC]) begin
        sel = IW'((int'(rr_q) + k) % N_SRC);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    gap_d   = gap_q;
    unique case (state_q)
      IDLE: begin
        if (|s_axis_valid) begin
          idx_d   = sel;
          grant_d = N_SRC'(1) << sel;
          state_d = (HEADER_EN != 0) ? HDR : DATA;
        end
      end
      HDR: begin
        if (m_axis_ready) state_d = DATA;
      end
      DATA: begin
        if (src_vld && m_axis_ready && src_last) begin
          rr_d    = (idx_q == IW'(N_SRC - 1)) ? '0 : idx_q + 1'b1;
          grant_d = '0;
          if (GAP_CYCLES > 0) begin
            state_d = GAP;
            gap_d   = GW'(GAP_CYCLES - 1);
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rr_q    <= '0;
      grant_q <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      gap_q   <= gap_d;
    end
  end

  // Handshakes are masked while rst_n is low so no beat completes
  // in the reset cycle.
  always_comb begin
    m_axis_data  = '0;
    m_axis_valid = 1'b0;
    m_axis_last  = 1'b0;
    s_axis_ready = '0;
    unique case (state_q)
      HDR: begin
        m_axis_data  = hdr;
        m_axis_valid = rst_n;
      end
      DATA: begin
        m_axis_data  = src_data;
        m_axis_valid = src_vld & rst_n;
        m_axis_last  = src_last;
        s_axis_ready = grant_q & {N_SRC{m_axis_ready & rst_n}};
      end
      default: ;
    endcase
  end

  assign grant = grant_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_axis_uart_tx_arbiter.sv
// Randomized scoreboard bench for axis_uart_tx_arbiter: packet-level
// round-robin model predicts owner order, headers, timing and gaps.
module tb_axis_uart_tx_arbiter;

  localparam int         N   = 4;
  localparam int         DW  = 8;
  localparam int         GAP = 2;
  localparam logic [7:0] HB  = 8'hA0;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N*DW-1:0]   s_axis_data = '0;
  logic [N-1:0]      s_axis_valid = '0;
  logic [N-1:0]      s_axis_last = '0;
  logic [N-1:0]      s_axis_ready;
  logic [DW-1:0]     m_axis_data;
  logic              m_axis_valid;
  logic              m_axis_last;
  logic              m_axis_ready = 1'b0;
  logic [N-1:0]      grant;
  logic              busy;

  axis_uart_tx_arbiter #(
    .DATA_BITS(DW), .N_SRC(N), .HEADER_EN(1),
    .HDR_BASE(HB), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_data(s_axis_data), .s_axis_valid(s_axis_valid),
    .s_axis_last(s_axis_last), .s_axis_ready(s_axis_ready),
    .m_axis_data(m_axis_data), .m_axis_valid(m_axis_valid),
    .m_axis_last(m_axis_last), .m_axis_ready(m_axis_ready),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // source stimulus state
  logic [7:0] pkt [N][4];
  int  plen [N];
  int  beat [N];
  int  wt [N];
  bit  has_pkt [N];
  bit  vld [N];
  bit  gen_en = 1'b0;

  // scoreboard / reference model state
  logic [DW:0] exp_q [$];
  int  rr = 0;
  bit  mbusy = 1'b0;
  bit  hdr_ph = 1'b0;
  int  owner = 0;
  int  free_at = 0;
  int  hdr_due = -1;
  logic [DW-1:0] hdr_exp;
  bit  pv = 1'b0;
  bit  pr = 1'b0;
  logic [DW-1:0] pd;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h",
               nm, cyc, act, exp);
    end
  endtask

  // monitor + packet-level reference model
  always @(negedge clk) begin
    logic [N-1:0] eg;
    logic [DW:0]  e;
    bit           midle;
    int           w;
    bit           found;
    if (!rst_n) begin
      exp_q.delete();
      rr = 0; mbusy = 0; hdr_ph = 0;
      free_at = cyc + 1; hdr_due = -1; pv = 0;
    end else begin
      midle = !mbusy && (cyc >= free_at);
      eg = mbusy ? N'(1) << owner : '0;
      chk("busy", 32'(busy), 32'(!midle));
      chk("grant", 32'(grant), 32'(eg));
      chk("ready_mask", 32'(s_axis_ready & ~eg), 0);
      if (mbusy)
        chk("ready_owner", 32'(s_axis_ready[owner]),
            32'(hdr_ph ? 1'b0 : m_axis_ready));
      else
        chk("m_valid_idle", 32'(m_axis_valid), 0);
      if (cyc == hdr_due) begin
        chk("hdr_latency_valid", 32'(m_axis_valid), 1);
        chk("hdr_latency_data", 32'(m_axis_data), 32'(hdr_exp));
      end
      if (pv && !pr) begin
        chk("stall_valid", 32'(m_axis_valid), 1);
        chk("stall_data", 32'(m_axis_data), 32'(pd));
      end
      if (m_axis_valid && m_axis_ready) begin
        hdr_ph = 0;
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 32'(m_axis_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", 32'(m_axis_data), 32'(e[DW-1:0]));
          chk("beat_last", 32'(m_axis_last), 32'(e[DW]));
          if (e[DW]) begin
            mbusy = 0;
            free_at = cyc + GAP + 1;
          end
        end
      end
      if (midle && |s_axis_valid) begin
        found = 0; w = 0;
        for (int k = 0; k < N; k++) begin
          if (!found && s_axis_valid[(rr + k) % N]) begin
            found = 1; w = (rr + k) % N;
          end
        end
        hdr_exp = HB + 8'(w);
        exp_q.push_back({1'b0, hdr_exp});
        for (int b = 0; b < plen[w]; b++)
          exp_q.push_back({b == plen[w] - 1, pkt[w][b]});
        owner = w; mbusy = 1; hdr_ph = 1;
        rr = (w + 1) % N;
        hdr_due = cyc + 1;
      end
      pv = m_axis_valid; pr = m_axis_ready; pd = m_axis_data;
    end
  end

  task automatic start_pkt(input int s, input int len);
    plen[s] = len;
    for (int b = 0; b < 4; b++) pkt[s][b] = 8'($urandom);
    beat[s] = 0; has_pkt[s] = 1; vld[s] = 1; wt[s] = 0;
  endtask

  task automatic drive();
    for (int s = 0; s < N; s++) begin
      s_axis_valid[s] = vld[s];
      s_axis_data[s*DW +: DW] = pkt[s][beat[s]];
      s_axis_last[s] = vld[s] && (beat[s] == plen[s] - 1);
    end
  endtask

  task automatic step();
    logic [N-1:0] hs;
    logic rs;
    @(negedge clk);
    hs = s_axis_valid & s_axis_ready;
    rs = rst_n;
    @(posedge clk);
    #1;
    for (int s = 0; s < N; s++) begin
      if (!rs) begin
        if (has_pkt[s]) begin beat[s] = 0; vld[s] = 1; end
      end else if (hs[s]) begin
        if (beat[s] == plen[s] - 1) begin
          has_pkt[s] = 0; vld[s] = 0; wt[s] = $urandom_range(0, 6);
        end else begin
          beat[s]++;
          if ($urandom_range(0, 3) == 0) begin
            vld[s] = 0; wt[s] = $urandom_range(1, 5);
          end else vld[s] = 1;
        end
      end else if (!vld[s]) begin
        if (wt[s] > 0) wt[s]--;
        else if (has_pkt[s]) vld[s] = 1;
        else if (gen_en && $urandom_range(0, 2) == 0)
          start_pkt(s, $urandom_range(1, 4));
      end
    end
    m_axis_ready = ($urandom_range(0, 3) != 0);
    drive();
  endtask

  task automatic drain();
    bit done;
    gen_en = 0;
    done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      step();
      done = !mbusy && exp_q.size() == 0 && !has_pkt[0] &&
             !has_pkt[1] && !has_pkt[2] && !has_pkt[3];
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain_timeout: got pending expected none");
    end
  endtask

  initial begin
    bit hit;
    for (int s = 0; s < N; s++) begin
      plen[s] = 1; beat[s] = 0; wt[s] = 0; has_pkt[s] = 0; vld[s] = 0;
      for (int b = 0; b < 4; b++) pkt[s][b] = '0;
    end
    drive();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) step();

    gen_en = 1;
    repeat (4000) step();
    drain();

    // source 3 sends 4 bytes; reset hits while byte 2 is offered
    start_pkt(3, 4);
    drive();
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      step();
      hit = has_pkt[3] && vld[3] && beat[3] == 1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL reset_setup_timeout: got no byte2 expected byte2");
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    start_pkt(0, 2);
    drive();
    drain();

    gen_en = 1;
    repeat (1500) step();
    drain();

    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
